// File: rtl/sc_mnist_pkg.sv
// Shared definitions for the stochastic-computing MNIST inference controller.
//   state_t  : sequencer states (IDLE, CLEAR, WARMUP, RUN, SCAN, DONE)
//   N0/N1/N2 : default layer sizes of the two-layer APC-neuron network
//   STREAM_LEN : default bitstream length per inference
//   max_int  : helper for sizing shared counters from several parameters
package sc_mnist_pkg;

    localparam int N0         = 784;
    localparam int N1         = 128;
    localparam int N2         = 10;
    localparam int STREAM_LEN = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WARMUP,
        RUN,
        SCAN,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sc_argmax_scan.sv
// Sequential argmax over per-class ones counts, one class per cycle.
// Optional feature macro: SC_INFERENCE_CTRL_MARGIN_EN (adds second-best
// tracking and the best_margin output).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cmp_en          : a count is presented this cycle
//   cmp_first       : this is the first count of a scan (index 0)
//   cmp_idx/cmp_cnt : class index and its count
//   best_idx/best_cnt : running (and, after the scan, final) winner
//   best_margin     : winner count minus second-best count (macro only)
module sc_argmax_scan #(
    parameter int CW = 5,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmp_en,
    input  logic          cmp_first,
    input  logic [IW-1:0] cmp_idx,
    input  logic [CW-1:0] cmp_cnt,
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
    output logic [CW-1:0] best_margin,
`endif
    output logic [IW-1:0] best_idx,
    output logic [CW-1:0] best_cnt
);

    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [CW-1:0] best_cnt_q, best_cnt_d;
    logic [IW-1:0] base_idx;
    logic [CW-1:0] base_cnt;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
    logic [CW-1:0] second_q, second_d;
    logic [CW-1:0] base_second;
`endif

    always_comb begin
        // A scan starts from a (class 0, count 0) baseline so that an
        // all-zero count vector resolves to class 0 with count 0.
        base_idx   = cmp_first ? '0 : best_idx_q;
        base_cnt   = cmp_first ? '0 : best_cnt_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
        base_second = cmp_first ? '0 : second_q;
        second_d    = second_q;
`endif
        if (cmp_en) begin
            best_idx_d = base_idx;
            best_cnt_d = base_cnt;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
            second_d = base_second;
`endif
            // Strictly greater only: ties keep the lower index.
            if (cmp_cnt > base_cnt) begin
                best_idx_d = cmp_idx;
                best_cnt_d = cmp_cnt;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
                second_d = base_cnt;
            end else if (cmp_cnt > base_second) begin
                second_d = cmp_cnt;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx_q <= '0;
            best_cnt_q <= '0;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
            second_q   <= '0;
`endif
        end else begin
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
            second_q   <= second_d;
`endif
        end
    end

    assign best_idx = best_idx_q;
    assign best_cnt = best_cnt_q;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
    assign best_margin = best_cnt_q - second_q;
`endif

endmodule

// File: rtl/sc_inference_ctrl.sv
// Sequencer for one stochastic-computing MNIST inference.
// Optional feature macro: SC_INFERENCE_CTRL_MARGIN_EN (adds result_margin).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : request an inference (sampled in IDLE only)
//   busy            : high outside IDLE
//   net_rst, sng_en : network reset and SNG enable
//   net_dout        : one output bitstream bit per class per cycle
//   result_valid/result_ready : result handshake
//   result_class/result_count : winning class and its ones count
//   result_margin   : winner minus second-best count (macro only)
//
// state  | meaning
// IDLE   | network held in reset, waiting for start
// CLEAR  | network reset held for CLR_CYC cycles
// WARMUP | SNGs running, PIPE_LAT pipeline samples discarded
// RUN    | STREAM_LEN cycles of per-class ones counting
// SCAN   | one class count compared per cycle, N2 cycles
// DONE   | result presented until accepted
module sc_inference_ctrl
    import sc_mnist_pkg::*;
#(
    parameter int N2         = sc_mnist_pkg::N2,
    parameter int STREAM_LEN = sc_mnist_pkg::STREAM_LEN,
    parameter int CLR_CYC    = 2,
    parameter int PIPE_LAT   = 2,
    parameter int CW         = $clog2(STREAM_LEN + 1),
    parameter int IW         = $clog2(N2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          net_rst,
    output logic          sng_en,
    input  logic [N2-1:0] net_dout,
    output logic          result_valid,
    input  logic          result_ready,
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
    output logic [CW-1:0] result_margin,
`endif
    output logic [IW-1:0] result_class,
    output logic [CW-1:0] result_count
);

    localparam int PMAX = max_int(max_int(CLR_CYC, PIPE_LAT), max_int(STREAM_LEN, N2));
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] LD_CLR  = PW'(CLR_CYC - 1);
    localparam logic [PW-1:0] LD_WARM = PW'(PIPE_LAT - 1);
    localparam logic [PW-1:0] LD_RUN  = PW'(STREAM_LEN - 1);
    localparam logic [PW-1:0] LD_SCAN = PW'(N2 - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] cnt_q [N2];
    logic [CW-1:0] cnt_d [N2];
    logic          phase_tc;
    logic          cmp_en;
    logic          cmp_first;
    logic [IW-1:0] cmp_idx;

    assign phase_tc = (phase_q == '0);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        for (int i = 0; i < N2; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    phase_d = LD_CLR;
                    for (int i = 0; i < N2; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            CLEAR: begin
                if (phase_tc) begin
                    if (PIPE_LAT > 0) begin
                        state_d = WARMUP;
                        phase_d = LD_WARM;
                    end else begin
                        state_d = RUN;
                        phase_d = LD_RUN;
                    end
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            WARMUP: begin
                if (phase_tc) begin
                    state_d = RUN;
                    phase_d = LD_RUN;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            RUN: begin
                for (int i = 0; i < N2; i++) begin
                    cnt_d[i] = cnt_q[i] + CW'(net_dout[i]);
                end
                if (phase_tc) begin
                    state_d = SCAN;
                    phase_d = LD_SCAN;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            SCAN: begin
                if (phase_tc) begin
                    state_d = DONE;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            for (int i = 0; i < N2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            for (int i = 0; i < N2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // The scan walks index 0 upward while the shared phase counter counts down.
    assign cmp_en    = (state_q == SCAN);
    assign cmp_first = (phase_q == LD_SCAN);
    assign cmp_idx   = IW'(LD_SCAN - phase_q);

    sc_argmax_scan #(
        .CW(CW),
        .IW(IW)
    ) u_scan (
        .clk        (clk),
        .rst        (reset),
        .cmp_en     (cmp_en),
        .cmp_first  (cmp_first),
        .cmp_idx    (cmp_idx),
        .cmp_cnt    (cnt_q[cmp_idx]),
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
        .best_margin(result_margin),
`endif
        .best_idx   (result_class),
        .best_cnt   (result_count)
    );

    assign busy         = (state_q != IDLE);
    assign sng_en       = (state_q == WARMUP) || (state_q == RUN);
    assign net_rst      = !sng_en;
    assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_sc_inference_ctrl.sv
module tb_sc_inference_ctrl;

    localparam int N2  = 10;
    localparam int SL  = 16;
    localparam int CC  = 2;
    localparam int PL  = 2;
    localparam int CW  = $clog2(SL + 1);
    localparam int IW  = $clog2(N2);
    localparam int LAT = CC + PL + SL + N2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          net_rst;
    logic          sng_en;
    logic [N2-1:0] net_dout;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] result_class;
    logic [CW-1:0] result_count;
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
    logic [CW-1:0] result_margin;
`endif

    sc_inference_ctrl #(
        .N2(N2),
        .STREAM_LEN(SL),
        .CLR_CYC(CC),
        .PIPE_LAT(PL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .net_rst      (net_rst),
        .sng_en       (sng_en),
        .net_dout     (net_dout),
        .result_valid (result_valid),
        .result_ready (result_ready),
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
        .result_margin(result_margin),
`endif
        .result_class (result_class),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [N2-1:0] pat [SL];
    logic [N2-1:0] warm_val;
    logic          obs_busy  [LAT+1];
    logic          obs_nrst  [LAT+1];
    logic          obs_sng   [LAT+1];
    logic          obs_valid [LAT+1];
    int            exp_class;
    int            exp_count;
    int            exp_margin;

    // Reference: count ones per class, winner is the first class holding the
    // maximum, margin is the winner minus the largest count among the others.
    function automatic void ref_model();
        int cnt [N2];
        int best;
        int second;
        for (int i = 0; i < N2; i++) cnt[i] = 0;
        for (int c = 0; c < SL; c++)
            for (int i = 0; i < N2; i++)
                if (pat[c][i]) cnt[i]++;
        best = 0;
        for (int i = 0; i < N2; i++) if (cnt[i] > best) best = cnt[i];
        exp_class = 0;
        for (int i = N2 - 1; i >= 0; i--) if (cnt[i] == best) exp_class = i;
        second = 0;
        for (int i = 0; i < N2; i++) if (i != exp_class && cnt[i] > second) second = cnt[i];
        exp_count  = best;
        exp_margin = best - second;
    endfunction

    // j = cycles since the start edge; streaming covers WARMUP and RUN.
    function automatic logic exp_stream(input int j);
        return (j >= CC) && (j < CC + PL + SL);
    endfunction

    // Pulse start, then drive the inference with garbage outside RUN/WARMUP,
    // warm_val during WARMUP and pat during RUN; records outputs per cycle.
    task automatic do_run(input bit noise);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            obs_busy[k-1]  = busy;
            obs_nrst[k-1]  = net_rst;
            obs_sng[k-1]   = sng_en;
            obs_valid[k-1] = result_valid;
            if (k <= CC) net_dout = N2'($urandom);
            else if (k <= CC + PL) net_dout = warm_val;
            else if (k <= CC + PL + SL) net_dout = pat[k-CC-PL-1];
            else net_dout = N2'($urandom);
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        obs_busy[LAT]  = busy;
        obs_nrst[LAT]  = net_rst;
        obs_sng[LAT]   = sng_en;
        obs_valid[LAT] = result_valid;
        start    = 1'b0;
        net_dout = '0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || net_rst !== 1'b1 || sng_en !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b net_rst=%b sng_en=%b valid=%b, want 0 1 0 0",
                     busy, net_rst, sng_en, result_valid);
        end
        checks++;
        if (result_class !== '0 || result_count !== '0) begin
            errors++;
            $display("FAIL reset_result: class=%0d count=%0d, want 0 0", result_class, result_count);
        end
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
        checks++;
        if (result_margin !== '0) begin
            errors++;
            $display("FAIL reset_margin: got %0d want 0", result_margin);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || net_rst !== 1'b1 || sng_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b net_rst=%b sng_en=%b, want 0 1 0",
                     busy, net_rst, sng_en);
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < SL; c++) pat[c] = 10'b0000001000;
        warm_val = N2'($urandom);
        ref_model();
        do_run(1'b0);
        for (int j = 0; j <= LAT; j++) begin
            checks++;
            if (obs_nrst[j] !== !exp_stream(j) || obs_sng[j] !== exp_stream(j)) begin
                errors++;
                $display("FAIL basic_phase[%0d]: net_rst=%b sng_en=%b, want %b %b",
                         j, obs_nrst[j], obs_sng[j], !exp_stream(j), exp_stream(j));
            end
            checks++;
            if (obs_busy[j] !== 1'b1 || obs_valid[j] !== (j == LAT)) begin
                errors++;
                $display("FAIL basic_valid[%0d]: busy=%b valid=%b, want 1 %b",
                         j, obs_busy[j], obs_valid[j], j == LAT);
            end
        end
        checks++;
        if (result_class !== IW'(3) || result_count !== CW'(16) || exp_class != 3 || exp_count != 16) begin
            errors++;
            $display("FAIL basic_result: class=%0d count=%0d, want 3 16", result_class, result_count);
        end
        accept();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_class !== IW'(3) || result_count !== CW'(16)) begin
            errors++;
            $display("FAIL basic_accept: busy=%b valid=%b class=%0d count=%0d, want 0 0 3 16",
                     busy, result_valid, result_class, result_count);
        end
    endtask

    task automatic test_warmup_discard();
        int n;
        int p;
        for (int c = 0; c < SL; c++) pat[c] = '0;
        n = 0;
        while (n < 9) begin
            p = $urandom_range(0, SL - 1);
            if (!pat[p][5]) begin
                pat[p][5] = 1'b1;
                n++;
            end
        end
        warm_val = '1;
        ref_model();
        do_run(1'b0);
        checks++;
        if (result_valid !== 1'b1 || result_class !== IW'(exp_class) || result_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL warmup_discard: valid=%b class=%0d count=%0d, want 1 %0d %0d",
                     result_valid, result_class, result_count, exp_class, exp_count);
        end
        accept();
    endtask

    task automatic test_tie();
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < SL; c++) begin
                pat[c] = '0;
                pat[c][0] = (c < 3);
                pat[c][2] = (c < 12);
                pat[c][7] = (c >= 4 - pass);
            end
            warm_val = N2'($urandom);
            ref_model();
            do_run(1'b0);
            checks++;
            if (result_class !== IW'(exp_class) || result_count !== CW'(exp_count)) begin
                errors++;
                $display("FAIL tie_%0d: class=%0d count=%0d, want %0d %0d",
                         pass, result_class, result_count, exp_class, exp_count);
            end
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
            checks++;
            if (result_margin !== CW'(exp_margin)) begin
                errors++;
                $display("FAIL tie_margin_%0d: got %0d want %0d", pass, result_margin, exp_margin);
            end
`endif
            accept();
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < SL; c++) pat[c] = N2'($urandom);
        warm_val = N2'($urandom);
        ref_model();
        do_run(1'b1);
        result_ready = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            checks++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || result_class !== IW'(exp_class) ||
                result_count !== CW'(exp_count)) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b busy=%b class=%0d count=%0d, want 1 1 %0d %0d",
                         i, result_valid, busy, result_class, result_count, exp_class, exp_count);
            end
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
            checks++;
            if (result_margin !== CW'(exp_margin)) begin
                errors++;
                $display("FAIL hold_margin_%0d: got %0d want %0d", i, result_margin, exp_margin);
            end
`endif
            start = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        accept();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_class !== IW'(exp_class) ||
            result_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL bp_accept: busy=%b valid=%b class=%0d count=%0d, want 0 0 %0d %0d",
                     busy, result_valid, result_class, result_count, exp_class, exp_count);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle_stays: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start    = 1'b1;
        net_dout = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (CC + PL + 7) @(negedge clk);
        checks++;
        if (sng_en !== 1'b1 || net_rst !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_pre: sng_en=%b net_rst=%b, want 1 0", sng_en, net_rst);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (net_rst !== 1'b1 || sng_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: net_rst=%b sng_en=%b busy=%b valid=%b, want 1 0 0 0",
                     net_rst, sng_en, busy, result_valid);
        end
        checks++;
        if (result_class !== '0 || result_count !== '0) begin
            errors++;
            $display("FAIL mid_run_reset_result: class=%0d count=%0d, want 0 0", result_class, result_count);
        end
        @(negedge clk);
        reset    = 1'b0;
        net_dout = '0;
        for (int c = 0; c < SL; c++) begin
            pat[c] = '0;
            pat[c][4] = (c % 3 == 0);
            pat[c][8] = (c % 5 == 0);
        end
        warm_val = '1;
        ref_model();
        do_run(1'b0);
        checks++;
        if (result_class !== IW'(exp_class) || result_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL after_reset_run: class=%0d count=%0d, want %0d %0d",
                     result_class, result_count, exp_class, exp_count);
        end
        accept();
    endtask

    task automatic test_back_to_back_zero();
        for (int c = 0; c < SL; c++) pat[c] = N2'($urandom);
        warm_val = N2'($urandom);
        do_run(1'b0);
        start        = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b valid=%b, want 0 0", busy, result_valid);
        end
        @(negedge clk);
        start    = 1'b0;
        net_dout = '0;
        checks++;
        if (busy !== 1'b1 || net_rst !== 1'b1 || sng_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b net_rst=%b sng_en=%b, want 1 1 0", busy, net_rst, sng_en);
        end
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_early_valid: valid=%b want 0", result_valid);
        end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || result_class !== '0 || result_count !== '0) begin
            errors++;
            $display("FAIL zero_result: valid=%b class=%0d count=%0d, want 1 0 0",
                     result_valid, result_class, result_count);
        end
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
        checks++;
        if (result_margin !== '0) begin
            errors++;
            $display("FAIL zero_margin: got %0d want 0", result_margin);
        end
`endif
        accept();
    endtask

    task automatic test_random();
        logic [N2-1:0] mask;
        for (int it = 0; it < 8; it++) begin
            mask = N2'($urandom);
            for (int c = 0; c < SL; c++) pat[c] = N2'($urandom) & (mask | N2'($urandom));
            warm_val = N2'($urandom);
            ref_model();
            do_run(it[0]);
            checks++;
            if (result_valid !== 1'b1 || result_class !== IW'(exp_class) || result_count !== CW'(exp_count)) begin
                errors++;
                $display("FAIL random_%0d: valid=%b class=%0d count=%0d, want 1 %0d %0d",
                         it, result_valid, result_class, result_count, exp_class, exp_count);
            end
`ifdef SC_INFERENCE_CTRL_MARGIN_EN
            checks++;
            if (result_margin !== CW'(exp_margin)) begin
                errors++;
                $display("FAIL random_margin_%0d: got %0d want %0d", it, result_margin, exp_margin);
            end
`endif
            accept();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        net_dout     = '0;
        warm_val     = '0;
        test_reset();
        test_basic();
        test_warmup_discard();
        test_tie();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
